// File: rtl/rq_arb_pkg.sv
// Shared definitions for the two-source RQ arbiter.
// Contents: default stream and counter widths, the arbiter state enum,
// the one-hot grant encodings and a grant-to-state helper.
package rq_arb_pkg;

   localparam int DATA_W = 512;
   localparam int KEEP_W = 64;
   localparam int USER_W = 137;
   localparam int CNT_W  = 32;

   // State codes deliberately equal the grant code of the owning source
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } arb_state_t;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_S0   = 2'b01;
   localparam logic [1:0] GNT_S1   = 2'b10;

   // Map a one-hot grant from the selector onto the ownership state
   function automatic arb_state_t state_of_gnt(input logic [1:0] gnt);
      case (gnt)
         GNT_S0:  return OWN0;
         GNT_S1:  return OWN1;
         default: return IDLE;
      endcase
   endfunction

endpackage

// File: rtl/rq_arbiter_2x1_rr_pick2.sv
// rr_pick2: combinational two-requester round-robin selector.
// Ports:
//   i_req  [1:0]  request vector (bit n = source n)
//   i_last        index of the source served most recently
//   o_gnt  [1:0]  one-hot grant, 00 when nobody requests
//   o_any         at least one request present
module rr_pick2
   import rq_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic [1:0] o_gnt,
   output logic       o_any
);

   // Single requester wins outright; on a tie the one not served last wins
   always_comb begin
      o_gnt = GNT_NONE;
      case (i_req)
         2'b01:   o_gnt = GNT_S0;
         2'b10:   o_gnt = GNT_S1;
         2'b11:   o_gnt = i_last ? GNT_S0 : GNT_S1;
         default: o_gnt = GNT_NONE;
      endcase
   end

   assign o_any = |i_req;

endmodule

// File: rtl/rq_arbiter_2x1.sv
// rq_arbiter_2x1: packet-granular round-robin arbiter sharing one RQ
// AXI-stream between the DMA engine (source 0) and the DSM page-fetch
// engine (source 1). Packets are never interleaved; the datapath is a pure
// combinational mux selected by the registered owner.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   s0_axis_*, s1_axis_*     source streams (tdata/tkeep/tuser/tlast/tvalid in, tready out)
//   m_axis_*                 merged stream (tready in, the rest out)
//   pkt_cnt0, pkt_cnt1       packets completed per source (wrapping)
//   beat_cnt                 beats transferred on m_axis (wrapping)
//   grant                    one-hot owner, 00 when idle
module rq_arbiter_2x1
   import rq_arb_pkg::*;
#(
   parameter int DATA_W = rq_arb_pkg::DATA_W,
   parameter int KEEP_W = rq_arb_pkg::KEEP_W,
   parameter int USER_W = rq_arb_pkg::USER_W,
   parameter int CNT_W  = rq_arb_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s0_axis_tdata,
   input  logic [KEEP_W-1:0] s0_axis_tkeep,
   input  logic [USER_W-1:0] s0_axis_tuser,
   input  logic              s0_axis_tlast,
   input  logic              s0_axis_tvalid,
   output logic              s0_axis_tready,
   input  logic [DATA_W-1:0] s1_axis_tdata,
   input  logic [KEEP_W-1:0] s1_axis_tkeep,
   input  logic [USER_W-1:0] s1_axis_tuser,
   input  logic              s1_axis_tlast,
   input  logic              s1_axis_tvalid,
   output logic              s1_axis_tready,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic [KEEP_W-1:0] m_axis_tkeep,
   output logic [USER_W-1:0] m_axis_tuser,
   output logic              m_axis_tlast,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic [CNT_W-1:0]  pkt_cnt0,
   output logic [CNT_W-1:0]  pkt_cnt1,
   output logic [CNT_W-1:0]  beat_cnt,
   output logic [1:0]        grant
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   arb_state_t       r_state;
   logic [1:0]       r_grant;
   logic             r_last;
   logic             r_mid;
   logic [CNT_W-1:0] r_pkt_cnt0;
   logic [CNT_W-1:0] r_pkt_cnt1;
   logic [CNT_W-1:0] r_beat_cnt;

   logic             w_owner_v;
   logic             w_xfer;
   logic             w_eop;
   logic             w_regrant;
   logic             w_pick_last;
   logic [1:0]       w_pick_gnt;
   logic             w_pick_any;

   // Output mux and ready steering; handshakes are held off while rst is low
   always_comb begin
      m_axis_tdata   = {DATA_W{1'b0}};
      m_axis_tkeep   = {KEEP_W{1'b0}};
      m_axis_tuser   = {USER_W{1'b0}};
      m_axis_tlast   = 1'b0;
      m_axis_tvalid  = 1'b0;
      s0_axis_tready = 1'b0;
      s1_axis_tready = 1'b0;
      w_owner_v      = 1'b0;
      case (r_state)
         OWN0: begin
            m_axis_tdata   = s0_axis_tdata;
            m_axis_tkeep   = s0_axis_tkeep;
            m_axis_tuser   = s0_axis_tuser;
            m_axis_tlast   = s0_axis_tlast;
            m_axis_tvalid  = s0_axis_tvalid & rst;
            s0_axis_tready = m_axis_tready & rst;
            w_owner_v      = s0_axis_tvalid;
         end
         OWN1: begin
            m_axis_tdata   = s1_axis_tdata;
            m_axis_tkeep   = s1_axis_tkeep;
            m_axis_tuser   = s1_axis_tuser;
            m_axis_tlast   = s1_axis_tlast;
            m_axis_tvalid  = s1_axis_tvalid & rst;
            s1_axis_tready = m_axis_tready & rst;
            w_owner_v      = s1_axis_tvalid;
         end
         default: begin
            w_owner_v = 1'b0;
         end
      endcase
   end

   assign w_xfer = m_axis_tvalid & m_axis_tready;
   assign w_eop  = w_xfer & m_axis_tlast;

   // At packet end the finishing owner counts as "last served" this very
   // cycle, so the other source wins if it is waiting, else the owner keeps it.
   assign w_pick_last = w_eop ? (r_state == OWN1) : r_last;

   rr_pick2 u_pick (
      .i_req  ({s1_axis_tvalid, s0_axis_tvalid}),
      .i_last (w_pick_last),
      .o_gnt  (w_pick_gnt),
      .o_any  (w_pick_any)
   );

   // Decide when ownership may be re-evaluated: always in IDLE, at packet end,
   // or at a packet boundary where the owner has nothing left to offer
   always_comb begin
      w_regrant = 1'b0;
      case (r_state)
         IDLE:       w_regrant = 1'b1;
         OWN0, OWN1: w_regrant = w_eop | (~r_mid & ~w_owner_v & m_axis_tready);
         default:    w_regrant = 1'b1;
      endcase
   end

   // Ownership FSM: state, registered grant, round-robin pointer, in-packet flag
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_grant <= GNT_NONE;
         r_last  <= 1'b1;
         r_mid   <= 1'b0;
      end else begin
         if (w_regrant) begin
            r_state <= state_of_gnt(w_pick_gnt);
            r_grant <= w_pick_gnt;
         end
         if (w_eop) begin
            r_last <= (r_state == OWN1);
            r_mid  <= 1'b0;
         end else if (w_xfer) begin
            r_mid  <= 1'b1;
         end
      end
   end

   // Statistics counters; they wrap freely and clear only on reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pkt_cnt0 <= {CNT_W{1'b0}};
         r_pkt_cnt1 <= {CNT_W{1'b0}};
         r_beat_cnt <= {CNT_W{1'b0}};
      end else begin
         if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + CNT_ONE;
         end
         if (w_eop && (r_state == OWN0)) begin
            r_pkt_cnt0 <= r_pkt_cnt0 + CNT_ONE;
         end
         if (w_eop && (r_state == OWN1)) begin
            r_pkt_cnt1 <= r_pkt_cnt1 + CNT_ONE;
         end
      end
   end

   assign pkt_cnt0 = r_pkt_cnt0;
   assign pkt_cnt1 = r_pkt_cnt1;
   assign beat_cnt = r_beat_cnt;
   assign grant    = r_grant;

   // The pick result is only meaningful as a grant; w_pick_any is kept for visibility
   logic w_unused;
   assign w_unused = w_pick_any;

endmodule

// File: tb/tb_rq_arbiter_2x1.sv
// Self-checking bench for rq_arbiter_2x1: a per-cycle vector table for the
// directed scenarios, a counter-wrap sequence, and a randomized run checked
// against a packet-level reference model.
module tb_rq_arbiter_2x1;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [511:0] s_tdata  [2];
   logic [63:0]  s_tkeep  [2];
   logic [136:0] s_tuser  [2];
   logic         s_tlast  [2];
   logic         s_tvalid [2];
   logic         s0_tready, s1_tready;
   logic [511:0] m_tdata;
   logic [63:0]  m_tkeep;
   logic [136:0] m_tuser;
   logic         m_tlast, m_tvalid, m_tready;
   logic [31:0]  pkt_cnt0, pkt_cnt1, beat_cnt;
   logic [1:0]   grant;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rq_arbiter_2x1 dut (
      .clk(clk), .rst(rst),
      .s0_axis_tdata(s_tdata[0]), .s0_axis_tkeep(s_tkeep[0]), .s0_axis_tuser(s_tuser[0]),
      .s0_axis_tlast(s_tlast[0]), .s0_axis_tvalid(s_tvalid[0]), .s0_axis_tready(s0_tready),
      .s1_axis_tdata(s_tdata[1]), .s1_axis_tkeep(s_tkeep[1]), .s1_axis_tuser(s_tuser[1]),
      .s1_axis_tlast(s_tlast[1]), .s1_axis_tvalid(s_tvalid[1]), .s1_axis_tready(s1_tready),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
      .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .beat_cnt(beat_cnt), .grant(grant)
   );

   // in = {rst, s0_valid, s0_last, s1_valid, s1_last, m_ready}
   // o  = {s0_ready, s1_ready, m_valid, check_counters}
   typedef struct {
      logic [5:0] in;
      logic [1:0] g;
      logic [3:0] o;
      int         p0, p1, b;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic [5:0] in, input logic [1:0] g, input logic [3:0] o,
                      input int p0, input int p1, input int b);
      vec_t e;
      e.in = in; e.g = g; e.o = o; e.p0 = p0; e.p1 = p1; e.b = b;
      tbl.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic rand_beat(input int n);
      for (int w = 0; w < 16; w++) s_tdata[n][w*32 +: 32] = $urandom;
      s_tkeep[n] = {$urandom, $urandom};
      s_tuser[n] = {9'($urandom), $urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic check_outs(input logic [1:0] g, input logic r0, input logic r1,
                             input logic mv, input logic ck,
                             input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] b);
      int o;
      chk("grant", grant, g);
      chk("s0_tready", s0_tready, r0);
      chk("s1_tready", s1_tready, r1);
      chk("m_tvalid", m_tvalid, mv);
      if (ck) begin
         chk("pkt_cnt0", pkt_cnt0, p0);
         chk("pkt_cnt1", pkt_cnt1, p1);
         chk("beat_cnt", beat_cnt, b);
      end
      if (g == 2'b01 || g == 2'b10) begin
         o = (g == 2'b10) ? 1 : 0;
         chk("m_tdata", m_tdata, s_tdata[o]);
         chk("m_tkeep", m_tkeep, s_tkeep[o]);
         chk("m_tuser", m_tuser, s_tuser[o]);
         chk("m_tlast", m_tlast, s_tlast[o]);
      end
   endtask

   // Reference model state for the random phase
   int          own, lst;
   bit          mid;
   logic [31:0] mp0, mp1, mb;
   int          plen [2];
   int          pbeat[2];
   bit          acc  [2];

   initial begin
      vec_t v;
      logic [1:0] eg;
      logic er0, er1, emv;
      int o;

      for (int n = 0; n < 2; n++) begin
         s_tvalid[n] = 1'b0; s_tlast[n] = 1'b0; rand_beat(n);
      end
      m_tready = 1'b1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // s0 alone, 3-beat packet
      add(6'b110001, 2'b00, 4'b0001, 0, 0, 0);
      add(6'b110001, 2'b01, 4'b1011, 0, 0, 0);
      add(6'b110001, 2'b01, 4'b1011, 0, 0, 1);
      add(6'b111001, 2'b01, 4'b1011, 0, 0, 2);
      add(6'b100001, 2'b01, 4'b1001, 1, 0, 3);
      add(6'b100001, 2'b00, 4'b0001, 1, 0, 3);
      // reset, then both sources stream 2-beat packets
      add(6'b010101, 2'b00, 4'b0000, 0, 0, 0);
      add(6'b110101, 2'b00, 4'b0001, 0, 0, 0);
      add(6'b110101, 2'b01, 4'b1011, 0, 0, 0);
      add(6'b111101, 2'b01, 4'b1011, 0, 0, 1);
      add(6'b110101, 2'b10, 4'b0111, 1, 0, 2);
      add(6'b110111, 2'b10, 4'b0111, 1, 0, 3);
      add(6'b110101, 2'b01, 4'b1011, 1, 1, 4);
      add(6'b111101, 2'b01, 4'b1011, 1, 1, 5);
      add(6'b110101, 2'b10, 4'b0111, 2, 1, 6);
      add(6'b100111, 2'b10, 4'b0111, 2, 1, 7);
      add(6'b100001, 2'b10, 4'b0101, 2, 2, 8);
      add(6'b100001, 2'b00, 4'b0001, 2, 2, 8);
      // s1 waits while s0 stalls mid-packet
      add(6'b110001, 2'b00, 4'b0001, 2, 2, 8);
      add(6'b110101, 2'b01, 4'b1011, 2, 2, 8);
      add(6'b100101, 2'b01, 4'b1001, 2, 2, 9);
      add(6'b100101, 2'b01, 4'b1001, 2, 2, 9);
      add(6'b111101, 2'b01, 4'b1011, 2, 2, 9);
      add(6'b100111, 2'b10, 4'b0111, 3, 2, 10);
      add(6'b100001, 2'b10, 4'b0101, 3, 3, 11);
      add(6'b100001, 2'b00, 4'b0001, 3, 3, 11);
      // 4-beat s1 packet with m_tready toggling
      add(6'b100101, 2'b00, 4'b0001, 3, 3, 11);
      add(6'b100101, 2'b10, 4'b0111, 3, 3, 11);
      add(6'b100100, 2'b10, 4'b0011, 3, 3, 12);
      add(6'b100101, 2'b10, 4'b0111, 3, 3, 12);
      add(6'b100100, 2'b10, 4'b0011, 3, 3, 13);
      add(6'b100101, 2'b10, 4'b0111, 3, 3, 13);
      add(6'b100100, 2'b10, 4'b0011, 3, 3, 14);
      add(6'b100111, 2'b10, 4'b0111, 3, 3, 14);
      add(6'b100000, 2'b10, 4'b0001, 3, 4, 15);
      add(6'b100001, 2'b10, 4'b0101, 3, 4, 15);
      add(6'b100001, 2'b00, 4'b0001, 3, 4, 15);
      // reset on beat 2 of an s0 packet, then s1 single-beat packet
      add(6'b110001, 2'b00, 4'b0001, 3, 4, 15);
      add(6'b110001, 2'b01, 4'b1011, 3, 4, 15);
      add(6'b010001, 2'b01, 4'b0000, 0, 0, 0);
      add(6'b100101, 2'b00, 4'b0001, 0, 0, 0);
      add(6'b100111, 2'b10, 4'b0111, 0, 0, 0);
      add(6'b100001, 2'b10, 4'b0101, 0, 1, 1);
      add(6'b100001, 2'b00, 4'b0001, 0, 1, 1);

      foreach (tbl[i]) begin
         v = tbl[i];
         rst = v.in[5];
         s_tvalid[0] = v.in[4]; s_tlast[0] = v.in[3];
         s_tvalid[1] = v.in[2]; s_tlast[1] = v.in[1];
         m_tready = v.in[0];
         rand_beat(0); rand_beat(1);
         @(negedge clk);
         check_outs(v.g, v.o[3], v.o[2], v.o[1], v.o[0], v.p0, v.p1, v.b);
         @(posedge clk);
         #1;
      end

      // Counter wrap: preload pkt_cnt0 with all ones, then send one s0 packet
      s_tvalid[0] = 1'b0; s_tvalid[1] = 1'b0; m_tready = 1'b1;
      force dut.r_pkt_cnt0 = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("wrap_preload", pkt_cnt0, 32'hFFFF_FFFF);
      @(posedge clk);
      #1 release dut.r_pkt_cnt0;
      s_tvalid[0] = 1'b1; s_tlast[0] = 1'b1; rand_beat(0);
      @(negedge clk);
      chk("wrap_idle_grant", grant, 2'b00);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("wrap_m_tvalid", m_tvalid, 1'b1);
      chk("wrap_before", pkt_cnt0, 32'hFFFF_FFFF);
      @(posedge clk);
      #1 s_tvalid[0] = 1'b0;
      @(negedge clk);
      chk("wrap_pkt_cnt0", pkt_cnt0, 32'h0000_0000);
      chk("wrap_beat_cnt", beat_cnt, 32'd2);

      // Randomized traffic against the reference model
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      own = -1; lst = 1; mid = 1'b0;
      mp0 = 32'd0; mp1 = 32'd0; mb = 32'd0;
      for (int n = 0; n < 2; n++) begin
         plen[n] = $urandom_range(1, 4); pbeat[n] = 0; acc[n] = 1'b0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int n = 0; n < 2; n++) begin
            if (acc[n]) s_tvalid[n] = 1'b0;
            acc[n] = 1'b0;
            if (!s_tvalid[n] && $urandom_range(0, 99) < 55) begin
               s_tvalid[n] = 1'b1;
               s_tlast[n]  = (pbeat[n] == plen[n] - 1);
               rand_beat(n);
            end
         end
         m_tready = ($urandom_range(0, 3) != 0);

         eg = 2'b00; er0 = 1'b0; er1 = 1'b0; emv = 1'b0;
         if (own == 0) begin
            eg = 2'b01; er0 = m_tready; emv = s_tvalid[0];
         end else if (own == 1) begin
            eg = 2'b10; er1 = m_tready; emv = s_tvalid[1];
         end
         @(negedge clk);
         check_outs(eg, er0, er1, emv, 1'b1, mp0, mp1, mb);

         // Advance the model across the coming clock edge
         if (own < 0) begin
            if (s_tvalid[0] && s_tvalid[1]) own = (lst == 0) ? 1 : 0;
            else if (s_tvalid[0])           own = 0;
            else if (s_tvalid[1])           own = 1;
         end else if (emv && m_tready) begin
            o = own;
            mb = mb + 32'd1;
            acc[o] = 1'b1;
            pbeat[o]++;
            if (s_tlast[o]) begin
               if (o == 0) mp0 = mp0 + 32'd1;
               else        mp1 = mp1 + 32'd1;
               lst = o; mid = 1'b0;
               pbeat[o] = 0; plen[o] = $urandom_range(1, 4);
               if (s_tvalid[1 - o]) own = 1 - o;
            end else begin
               mid = 1'b1;
            end
         end else if (!mid && !s_tvalid[own] && m_tready) begin
            own = s_tvalid[1 - own] ? 1 - own : -1;
         end
         @(posedge clk);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rq_arbiter_2x1.md
# rq_arbiter_2x1

Packet-granular round-robin arbiter that shares the single 512-bit PCIe requester-request (RQ) AXI-stream between two requesters, the DMA engine (source 0) and the DSM page-fetch engine (source 1). It sits upstream of the RQ/CC traffic counter. It guarantees that a packet is never interleaved with another, and it exports per-source packet and beat counts for software.

## Interface
- DATA_W, 512, tdata width
- KEEP_W, 64, tkeep width (DATA_W/8)
- USER_W, 137, tuser width (RQ sideband)
- CNT_W, 32, statistics counter width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- s0_axis_tdata/tkeep/tuser/tlast/tvalid  in  DATA_W/KEEP_W/USER_W/1/1  source 0 stream
- s0_axis_tready  out  1  source 0 ready
- s1_axis_tdata/tkeep/tuser/tlast/tvalid  in  DATA_W/KEEP_W/USER_W/1/1  source 1 stream
- s1_axis_tready  out  1  source 1 ready
- m_axis_tdata/tkeep/tuser/tlast/tvalid  out  DATA_W/KEEP_W/USER_W/1/1  merged RQ stream
- m_axis_tready  in  1  downstream ready
- pkt_cnt0, pkt_cnt1  out  CNT_W  packets completed per source
- beat_cnt  out  CNT_W  total beats transferred on m_axis
- grant  out  2  one-hot current owner; 00 when idle

## Operation
- FSM states: IDLE, OWN0, OWN1. Reset value is IDLE.
- Round-robin pointer `last` is reset to 1, so source 0 wins the first tie.
- IDLE:
  - Both s*_tready are 0 and m_axis_tvalid is 0.
  - If one source has tvalid, go to OWNn for that source.
  - If both have tvalid, grant the source not equal to `last`.
  - The decision takes effect on the next cycle.
- OWNn:
  - m_axis_* is driven combinationally from sn_axis_*.
  - sn_axis_tready = m_axis_tready. The other source's tready is 0.
- A transfer is a cycle with m_axis_tvalid && m_axis_tready.
- Packet end is a transfer with tlast=1. On packet end:
  - `last` is set to n, and pkt_cntn increments.
  - Next state is chosen the same cycle:
    - the other source if its tvalid=1;
    - else OWNn again if sn_tvalid=1 (it will present the next packet's first beat);
    - else IDLE.
  - Back-to-back packets therefore have no bubble.
- Ownership never changes mid-packet, even if the owner drops tvalid. The arbiter waits in OWNn.
- beat_cnt increments on every transfer.
- All counters wrap modulo 2^CNT_W without saturating.
- Counters and `last` clear only on reset.
- grant = 2'b01 in OWN0, 2'b10 in OWN1, 2'b00 in IDLE.

## Timing
- During reset, and on the first cycle after reset:
  - all tready and m_axis_tvalid are 0;
  - grant = 0;
  - all counters are 0.
- Latency from IDLE: the first beat is transferable 1 cycle after tvalid is first seen.
- Latency while owned: 0 cycles. The datapath is purely combinational; there is no storage on tdata.
- A tlast transfer is counted in the same edge as the state update, so pkt_cnt is visible 1 cycle after that beat.
- Single-beat packet (tlast on first beat): legal; the normal packet-end rules apply.
- Reset asserted mid-packet:
  - returns to IDLE immediately and the partial packet is abandoned;
  - no counter credit is given for it, since counters are cleared;
  - sources are reset by the same rst.
- m_axis_tready low holds all state. Counters do not advance.

## Structure
- Shared package rq_arb_pkg holds:
  - the state enum (IDLE/OWN0/OWN1);
  - default width constants DATA_W/KEEP_W/USER_W/CNT_W;
  - the one-hot grant encodings.
- One sub-module, rr_pick2: a combinational 2-requester round-robin selector.
  - Inputs: req[1:0], last. Outputs: gnt one-hot, any.
  - Used for both the IDLE grant and the packet-end re-grant.
- Counters and mux stay in the top module.

## Test plan
- Only s0 sends a 3-beat packet, m_tready=1: grant=01 one cycle after tvalid; 3 beats appear unchanged on m_axis; pkt_cnt0=1, beat_cnt=3; afterwards IDLE and grant=00.
- Both sources continuously offer 2-beat packets: output order s0,s1,s0,s1 with no idle cycle between packets; after 4 packets, pkt_cnt0=pkt_cnt1=2 and beat_cnt=8.
- s1 tvalid is asserted while s0 is mid-packet and s0 drops tvalid for 2 cycles: s1_tready stays 0 until s0's tlast; no interleaving occurs; s0 completes first.
- m_tready is toggled 1010… during a 4-beat s1 packet: each beat is transferred exactly once; beat_cnt=4 and the data matches the input order.
- pkt_cnt0 is preloaded by forcing 32'hFFFF_FFFF, then one packet is sent: pkt_cnt0 wraps to 0.
- rst is pulled low on beat 2 of a 4-beat s0 packet: the next cycle shows all counters 0, grant=00, all tready 0; after release, s1 arbitrates normally.
